inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Inverse of the core's immediate generator: packs decoded fields (opcode, registers, funct3, signed immediate) into a 32-bit RV32I word.
- Writes each word into instruction memory at a self-incrementing word address.
- Used by the boot/test loader to build programs in IMEM. Supports the same formats the core decodes: I-type (0010011, 0000011) and S-type (0100011).
- One output register stage with valid/ready backpressure from memory.

Parameters:
- ADDR_W, 10, IMEM word-address width.
- BASE_ADDR, 0, word address loaded on reset and on clear; must be < 2^ADDR_W.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous restart of address/count/wrapped; no effect on the pending word
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle this cycle
- in_opcode  input  7  opcode field
- in_rd  input  5  destination register (I-type only)
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2 (S-type only)
- in_funct3  input  3  funct3 field
- in_imm  input  32  signed immediate, two's complement
- mem_we  output  1  write request valid
- mem_ready  input  1  memory accepts the write this cycle
- mem_addr  output  ADDR_W  word address of the write
- mem_wdata  output  32  encoded instruction
- err  output  1  one-cycle pulse: last accepted bundle was rejected
- err_count  output  8  saturating count of rejected bundles
- word_count  output  ADDR_W+1  words written since reset/clear, saturating
- wrapped  output  1  sticky: address wrapped past 2^ADDR_W-1

Behaviour:
- Reset values: in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, err=0, err_count=0, word_count=0, wrapped=0.
- Handshakes:
  - Input accept = in_valid && in_ready.
  - Write accept = mem_we && mem_ready.
  - in_ready = !mem_we || mem_ready (combinational from mem_ready).
- FSM, two states:
  - EMPTY: mem_we=0. Legal accept -> FULL.
  - FULL: mem_we=1. Write accept with no new legal accept -> EMPTY. Write accept plus a simultaneous legal accept -> stays FULL with the new word.
- Latency: bundle accepted at edge N -> mem_we and mem_wdata valid from cycle N+1.
- While FULL and mem_ready=0: mem_wdata and mem_addr held stable, in_ready=0.
- Format selection by in_opcode:
  - 0010011 or 0000011 -> I.
  - 0100011 -> S.
  - Anything else -> illegal.
- Range check: in_imm[31:11] must be all-equal (range -2048..2047); otherwise illegal.
- Encoding:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - Unused fields (rs2 for I, rd for S) are ignored.
- Illegal bundle:
  - Is accepted (consumes the handshake) but produces no write and leaves the state unchanged.
  - err=1 in the following cycle; err_count increments, saturating at 255.
- Address handling:
  - mem_addr is the current write address; it increments on each write accept, modulo 2^ADDR_W.
  - A write accept at address 2^ADDR_W-1 -> next address 0 and wrapped set to 1.
  - word_count increments on each write accept, saturating at 2^ADDR_W.
- clear:
  - Next address=BASE_ADDR; word_count=0; wrapped=0; err_count=0.
  - A write accept in the same cycle completes at the old address and is not counted.
  - A pending FULL word is retained and written at BASE_ADDR.
  - clear has priority over the increment.
- rst mid-transfer: pending word dropped, all outputs return to reset values next cycle. rst has priority over clear and all handshakes.

Test Plan:
- addi x1,x0,5 (op 0010011, rd=1, rs1=0, f3=0, imm=5), mem_ready=1 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00500093, word_count=1.
- sw x2,8(x1) then lw x3,-4(x1) (imm=0xFFFFFFFC), back-to-back, mem_ready=1 -> 0x0020A423 at addr 0 then 0xFFC0A183 at addr 1, with no bubble.
- Backpressure: accept a word, hold mem_ready=0 for 3 cycles -> mem_wdata/mem_addr stable, in_ready=0; on the 4th cycle mem_ready=1 -> in_ready=1 and a new bundle is accepted in the same cycle.
- Illegal bundles: addi with imm=2048, then opcode 0110011 -> two err pulses, err_count=2, no mem_we, mem_addr unchanged.
- Wrap: ADDR_W=2, BASE_ADDR=0, 5 legal words -> addresses 0,1,2,3,0; wrapped=1 after the 4th write accept; word_count saturates at 4.
- clear coincident with a write accept at addr 5 (BASE_ADDR=0) -> that write at 5, next write at 0, word_count=0 then 1. Reset asserted while FULL -> mem_we=0, mem_addr=BASE_ADDR next cycle.

Source files
------------

// File: rtl/inst_encoder_if.sv
// Field-bundle input and IMEM write port of the instruction encoder.
// Valid/ready rule on both sides: a transfer happens on any rising edge where valid && ready.
interface inst_encoder_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic              in_ready;
   logic [6:0]        in_opcode;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [2:0]        in_funct3;
   logic [31:0]       in_imm;

   logic              mem_we;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   // Loader/memory side: supplies bundles and write acceptance.
   modport master (
      output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm,
      input  in_ready,
      input  mem_we, mem_addr, mem_wdata,
      output mem_ready
   );

   // Encoder side.
   modport slave (
      input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm,
      output in_ready,
      output mem_we, mem_addr, mem_wdata,
      input  mem_ready
   );
endinterface

// File: rtl/inst_encoder.sv
// Packs decoded RV32I I/S-type fields into instruction words and writes them
// to IMEM at a self-incrementing word address through a one-entry output stage.
module inst_encoder #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   inst_encoder_if.slave   bus,
   output logic            err,
   output logic [7:0]      err_count,
   output logic [ADDR_W:0] word_count,
   output logic            wrapped,
   output logic            dbg_state_o
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_e;

   localparam logic [6:0]        OP_IMM   = 7'b0010011;
   localparam logic [6:0]        OP_LOAD  = 7'b0000011;
   localparam logic [6:0]        OP_STORE = 7'b0100011;
   localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   WC_MAX   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   WC_ONE   = (ADDR_W+1)'(1);

   state_e            state_q, state_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   wcnt_q, wcnt_d;
   logic              wrap_q, wrap_d;
   logic              err_q, err_d;
   logic [7:0]        errc_q, errc_d;

   logic        is_i, is_s, imm_ok, legal;
   logic [31:0] enc_word;
   logic        in_ready, in_acc, wr_acc, legal_acc, illegal_acc;

   // Format decode, range check and packing of the incoming bundle.
   always_comb begin
      is_i   = (bus.in_opcode == OP_IMM) || (bus.in_opcode == OP_LOAD);
      is_s   = (bus.in_opcode == OP_STORE);
      // Immediate fits 12 signed bits only if bits 31..11 are a pure sign extension.
      imm_ok = (&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]);
      legal  = (is_i || is_s) && imm_ok;
      if (is_s) begin
         enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     bus.in_imm[4:0], bus.in_opcode};
      end else begin
         enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                     bus.in_opcode};
      end
   end

   assign in_ready    = (state_q == S_EMPTY) || bus.mem_ready;
   assign in_acc      = bus.in_valid && in_ready;
   assign wr_acc      = (state_q == S_FULL) && bus.mem_ready;
   assign legal_acc   = in_acc && legal;
   assign illegal_acc = in_acc && !legal;

   // Output stage FSM: EMPTY holds nothing, FULL presents one word to memory.
   always_comb begin
      state_d = state_q;
      wdata_d = wdata_q;
      case (state_q)
         S_EMPTY: begin
            if (legal_acc) state_d = S_FULL;
         end
         S_FULL: begin
            if (wr_acc && !legal_acc) state_d = S_EMPTY;
         end
         default: state_d = S_EMPTY;
      endcase
      if (legal_acc) wdata_d = enc_word;
   end

   // Address, word count and wrap tracking; clear wins over a coincident write.
   always_comb begin
      addr_d = addr_q;
      wcnt_d = wcnt_q;
      wrap_d = wrap_q;
      if (clear) begin
         addr_d = BASE;
         wcnt_d = '0;
         wrap_d = 1'b0;
      end else if (wr_acc) begin
         addr_d = addr_q + ADDR_ONE;
         if (addr_q == ADDR_MAX) wrap_d = 1'b1;
         if (wcnt_q != WC_MAX) wcnt_d = wcnt_q + WC_ONE;
      end
   end

   always_comb begin
      err_d  = illegal_acc;
      errc_d = errc_q;
      if (clear) begin
         errc_d = '0;
      end else if (illegal_acc && (errc_q != 8'hFF)) begin
         errc_d = errc_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         wdata_q <= '0;
         addr_q  <= BASE;
         wcnt_q  <= '0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
         errc_q  <= '0;
      end else begin
         state_q <= state_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         wcnt_q  <= wcnt_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
         errc_q  <= errc_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.mem_we    = (state_q == S_FULL);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign err           = err_q;
   assign err_count     = errc_q;
   assign word_count    = wcnt_q;
   assign wrapped       = wrap_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: two instances (10-bit and 2-bit address) share one
// stimulus stream and are compared every cycle against a field-level model.
module tb_inst_encoder;
  localparam int AW_A = 10;
  localparam int AW_B = 2;

  // ---------------- clock / reset / shared stimulus ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear, in_valid, mem_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;

  inst_encoder_if #(.ADDR_W(AW_A)) bus_a ();
  inst_encoder_if #(.ADDR_W(AW_B)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_opcode = in_opcode;
  assign bus_a.in_rd     = in_rd;
  assign bus_a.in_rs1    = in_rs1;
  assign bus_a.in_rs2    = in_rs2;
  assign bus_a.in_funct3 = in_funct3;
  assign bus_a.in_imm    = in_imm;
  assign bus_a.mem_ready = mem_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_opcode = in_opcode;
  assign bus_b.in_rd     = in_rd;
  assign bus_b.in_rs1    = in_rs1;
  assign bus_b.in_rs2    = in_rs2;
  assign bus_b.in_funct3 = in_funct3;
  assign bus_b.in_imm    = in_imm;
  assign bus_b.mem_ready = mem_ready;

  logic            err_a, wrap_a, dbg_a;
  logic [7:0]      errc_a;
  logic [AW_A:0]   wcnt_a;
  logic            err_b, wrap_b, dbg_b;
  logic [7:0]      errc_b;
  logic [AW_B:0]   wcnt_b;

  inst_encoder #(.ADDR_W(AW_A), .BASE_ADDR(0)) u_dut_a (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus_a),
    .err(err_a), .err_count(errc_a), .word_count(wcnt_a), .wrapped(wrap_a),
    .dbg_state_o(dbg_a)
  );

  inst_encoder #(.ADDR_W(AW_B), .BASE_ADDR(0)) u_dut_b (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus_b),
    .err(err_b), .err_count(errc_b), .word_count(wcnt_b), .wrapped(wrap_b),
    .dbg_state_o(dbg_b)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] exp_q[$];
  int m_addr[2];
  int m_cnt[2];
  int m_wrap[2];
  int aw[2];
  int m_err;
  int m_errc;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_encode(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    logic [31:0] w;
    if (op == 7'h23)
      w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
          (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
    else
      w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
          (32'(rd) << 7) | 32'(op);
    return w;
  endfunction

  function automatic bit ref_legal(input logic [6:0] op, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    return (op == 7'h13 || op == 7'h03 || op == 7'h23) && (s >= -2048) && (s <= 2047);
  endfunction

  task automatic check_outputs();
    bit pend;
    pend = (exp_q.size() != 0);
    check_val("in_ready_a", 32'(bus_a.in_ready), 32'(!pend || mem_ready));
    check_val("in_ready_b", 32'(bus_b.in_ready), 32'(!pend || mem_ready));
    check_val("mem_we_a", 32'(bus_a.mem_we), 32'(pend));
    check_val("mem_we_b", 32'(bus_b.mem_we), 32'(pend));
    if (pend) begin
      check_val("wdata_a", bus_a.mem_wdata, exp_q[0]);
      check_val("wdata_b", bus_b.mem_wdata, exp_q[0]);
    end
    check_val("addr_a", 32'(bus_a.mem_addr), m_addr[0]);
    check_val("addr_b", 32'(bus_b.mem_addr), m_addr[1]);
    check_val("wcnt_a", 32'(wcnt_a), m_cnt[0]);
    check_val("wcnt_b", 32'(wcnt_b), m_cnt[1]);
    check_val("wrap_a", 32'(wrap_a), m_wrap[0]);
    check_val("wrap_b", 32'(wrap_b), m_wrap[1]);
    check_val("err_a", 32'(err_a), m_err);
    check_val("err_b", 32'(err_b), m_err);
    check_val("errc_a", 32'(errc_a), m_errc);
    check_val("errc_b", 32'(errc_b), m_errc);
  endtask

  task automatic model_step();
    bit pend, acc, lg, wr;
    int lim;
    if (rst) begin
      exp_q.delete();
      for (int k = 0; k < 2; k++) begin
        m_addr[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0;
      end
      m_err = 0; m_errc = 0;
      return;
    end
    pend = (exp_q.size() != 0);
    acc  = in_valid && (!pend || mem_ready);
    lg   = ref_legal(in_opcode, in_imm);
    wr   = pend && mem_ready;
    if (wr) void'(exp_q.pop_front());
    for (int k = 0; k < 2; k++) begin
      lim = 1 << aw[k];
      if (clear) begin
        m_addr[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0;
      end else if (wr) begin
        if (m_addr[k] == lim - 1) m_wrap[k] = 1;
        m_addr[k] = (m_addr[k] + 1) % lim;
        if (m_cnt[k] < lim) m_cnt[k]++;
      end
    end
    if (acc && lg) exp_q.push_back(ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm));
    m_err = (acc && !lg) ? 1 : 0;
    if (clear) m_errc = 0;
    else if (m_err == 1 && m_errc < 255) m_errc++;
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set #1 after a rising edge; tick checks, advances the model, and moves one cycle.
  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm, input logic mr);
    set_bundle(op, rd, rs1, rs2, f3, imm);
    mem_ready = mr;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input logic mr, input int n);
    in_valid = 1'b0;
    mem_ready = mr;
    repeat (n) tick();
  endtask

  function automatic logic [6:0] rand_opcode();
    case ($urandom_range(0, 5))
      0, 1:    return 7'h13;
      2:       return 7'h03;
      3:       return 7'h23;
      4:       return 7'h33;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFFF800;
      1:       return 32'h000007FF;
      2:       return 32'h00000800;
      3:       return 32'hFFFFF7FF;
      4:       return $urandom;
      default: return 32'($signed($urandom_range(0, 4095)) - 2048);
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    aw[0] = AW_A; aw[1] = AW_B;
    for (int k = 0; k < 2; k++) begin
      m_addr[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0;
    end
    m_err = 0; m_errc = 0;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b0;
    check_val("rst_mem_we", 32'(bus_a.mem_we), 32'd0);
    check_val("rst_wdata", bus_a.mem_wdata, 32'd0);

    // addi x1,x0,5
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1);
    check_val("addi_we", 32'(bus_a.mem_we), 32'd1);
    check_val("addi_word", bus_a.mem_wdata, 32'h00500093);
    check_val("addi_addr", 32'(bus_a.mem_addr), 32'd0);
    idle(1'b1, 1);
    check_val("addi_wcnt", 32'(wcnt_a), 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;

    // sw x2,8(x1) then lw x3,-4(x1) back to back
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 1'b1);
    check_val("sw_word", bus_a.mem_wdata, 32'h0020A423);
    check_val("sw_addr", 32'(bus_a.mem_addr), 32'd0);
    send(7'h03, 5'd3, 5'd1, 5'd0, 3'd2, 32'hFFFFFFFC, 1'b1);
    check_val("lw_we", 32'(bus_a.mem_we), 32'd1);
    check_val("lw_word", bus_a.mem_wdata, 32'hFFC0A183);
    check_val("lw_addr", 32'(bus_a.mem_addr), 32'd1);

    // backpressure: addi x5,x6,-1 stalled for 3 cycles, then addi x7,x0,2047
    send(7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFFFFFF, 1'b1);
    set_bundle(7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 32'd2047);
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_val("bp_in_ready", 32'(bus_a.in_ready), 32'd0);
      check_val("bp_word", bus_a.mem_wdata, 32'hFFF30293);
      check_val("bp_addr", 32'(bus_a.mem_addr), 32'd2);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check_val("bp_release_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_val("bp_new_word", bus_a.mem_wdata, 32'h7FF00393);
    check_val("bp_new_addr", 32'(bus_a.mem_addr), 32'd3);
    idle(1'b1, 1);

    // illegal: out-of-range immediate, then R-type opcode
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 1'b1);
    check_val("ill1_err", 32'(err_a), 32'd1);
    send(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0, 1'b1);
    check_val("ill2_err", 32'(err_a), 32'd1);
    check_val("ill_errc", 32'(errc_a), 32'd2);
    check_val("ill_no_we", 32'(bus_a.mem_we), 32'd0);
    check_val("ill_addr", 32'(bus_a.mem_addr), 32'd4);
    idle(1'b1, 1);
    check_val("ill_err_drop", 32'(err_a), 32'd0);

    // wrap on the 2-bit instance: addresses 0,1,2,3,0
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(7'h13, 5'(k + 1), 5'd0, 5'd0, 3'd0, 32'(k), 1'b1);
      check_val("wrap_seq_addr", 32'(bus_b.mem_addr), 32'(k % 4));
      if (k == 3) check_val("wrap_not_yet", 32'(wrap_b), 32'd0);
    end
    check_val("wrap_set", 32'(wrap_b), 32'd1);
    check_val("wrap_cnt4", 32'(wcnt_b), 32'd4);
    idle(1'b1, 1);
    check_val("wrap_cnt_sat", 32'(wcnt_b), 32'd4);

    // clear coincident with a write at address 5
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < 6; k++) send(7'h03, 5'd4, 5'd2, 5'd0, 3'd2, 32'(4 * k), 1'b1);
    check_val("clr_pre_addr", 32'(bus_a.mem_addr), 32'd5);
    set_bundle(7'h23, 5'd0, 5'd2, 5'd9, 3'd2, 32'hFFFFFFF0);
    clear = 1'b1; mem_ready = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check_val("clr_addr", 32'(bus_a.mem_addr), 32'd0);
    check_val("clr_wcnt", 32'(wcnt_a), 32'd0);
    idle(1'b1, 1);
    check_val("clr_wcnt_after", 32'(wcnt_a), 32'd1);

    // reset while FULL
    send(7'h13, 5'd8, 5'd8, 5'd0, 3'd1, 32'd100, 1'b0);
    idle(1'b0, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_val("rstfull_we", 32'(bus_a.mem_we), 32'd0);
    check_val("rstfull_addr", 32'(bus_a.mem_addr), 32'd0);

    // err_count saturation
    for (int k = 0; k < 260; k++) send(7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1'b1);
    check_val("errc_sat", 32'(errc_a), 32'd255);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      clear     = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      in_opcode = rand_opcode();
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      in_imm    = rand_imm();
      tick();
    end
    rst = 1'b0; clear = 1'b0;
    idle(1'b1, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
